// File: rtl/wb_stage_buf.sv
// MEM->WB stage buffer: DEPTH-entry circular queue of LANES writeback records per entry.
// Optional newest-first forwarding lookup is built only when WB_STAGE_BUF_FWD_EN is defined.
module wb_stage_buf #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int LANES  = 1,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     hold,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*ADDR_W-1:0]  in_rd,
    input  logic [LANES*DATA_W-1:0]  in_vd,
    input  logic [LANES-1:0]         in_we,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*ADDR_W-1:0]  out_rd,
    output logic [LANES*DATA_W-1:0]  out_vd,
    output logic [LANES-1:0]         out_we,
    input  logic [ADDR_W-1:0]        fwd_addr,
    output logic                     fwd_hit,
    output logic [DATA_W-1:0]        fwd_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [LANES*ADDR_W-1:0] rd_mem [DEPTH];
    logic [LANES*DATA_W-1:0] vd_mem [DEPTH];
    logic [LANES-1:0]        we_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [LANES-1:0] we_in;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // in_ready ignores out_ready (a full buffer never accepts); both sides drop while hold or ~rdy.
    assign in_ready  = ~full & ~hold & rdy;
    assign out_valid = ~empty & ~hold & rdy;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Writes to x0 are architecturally discarded, so drop their enable at entry.
    always_comb begin
        we_in = '0;
        for (int i = 0; i < LANES; i++) begin
            we_in[i] = in_we[i] & (in_rd[i*ADDR_W +: ADDR_W] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int d = 0; d < DEPTH; d++) begin
                rd_mem[d] <= '0;
                vd_mem[d] <= '0;
                we_mem[d] <= '0;
            end
        end else if (rdy) begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                for (int d = 0; d < DEPTH; d++) begin
                    we_mem[d] <= '0;
                end
            end else begin
                if (push) begin
                    rd_mem[wr_ptr] <= in_rd;
                    vd_mem[wr_ptr] <= in_vd;
                    we_mem[wr_ptr] <= we_in;
                    wr_ptr         <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    assign out_rd = empty ? '0 : rd_mem[rd_ptr];
    assign out_vd = empty ? '0 : vd_mem[rd_ptr];
    assign out_we = empty ? '0 : we_mem[rd_ptr];

`ifdef WB_STAGE_BUF_FWD_EN
    // Walk oldest to newest and low lane to high lane; the last match wins,
    // which gives newest-entry, highest-lane priority.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CNT_W'(k) < count) begin
                for (int l = 0; l < LANES; l++) begin
                    if (we_mem[rd_ptr + PTR_W'(k)][l] &&
                        (rd_mem[rd_ptr + PTR_W'(k)][l*ADDR_W +: ADDR_W] == fwd_addr) &&
                        (fwd_addr != '0)) begin
                        fwd_hit  = 1'b1;
                        fwd_data = vd_mem[rd_ptr + PTR_W'(k)][l*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end
`else
    logic unused_fwd_addr;
    assign unused_fwd_addr = ^fwd_addr;
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

endmodule

// File: tb/tb_wb_stage_buf.sv
// Self-checking bench for wb_stage_buf: directed test-plan steps, then random traffic,
// all compared against a queue-based reference model of the writeback buffer.
module tb_wb_stage_buf;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int LANES  = 2;
    localparam int DEPTH  = 2;
    localparam int RD_W   = LANES * ADDR_W;
    localparam int VD_W   = LANES * DATA_W;
    localparam int ENT_W  = RD_W + VD_W + LANES;

    logic              clk;
    logic              rst;
    logic              rdy;
    logic              hold;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [RD_W-1:0]   in_rd;
    logic [VD_W-1:0]   in_vd;
    logic [LANES-1:0]  in_we;
    logic              out_valid;
    logic              out_ready;
    logic [RD_W-1:0]   out_rd;
    logic [VD_W-1:0]   out_vd;
    logic [LANES-1:0]  out_we;
    logic [ADDR_W-1:0] fwd_addr;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard: entries in arrival order, packed as {we, vd, rd} with x0 enables dropped.
    logic [ENT_W-1:0] exp_q[$];

    wb_stage_buf #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .hold(hold), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_vd(in_vd), .in_we(in_we),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rd(out_rd), .out_vd(out_vd), .out_we(out_we),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [ENT_W-1:0] make_entry(input logic [RD_W-1:0] rd,
                                                    input logic [VD_W-1:0] vd,
                                                    input logic [LANES-1:0] we);
        logic [LANES-1:0] we_s;
        for (int l = 0; l < LANES; l++)
            we_s[l] = we[l] && (rd[l*ADDR_W +: ADDR_W] != 0);
        return {we_s, vd, rd};
    endfunction

    task automatic model_fwd(input logic [ADDR_W-1:0] a, output logic hit, output logic [DATA_W-1:0] data);
        logic [ENT_W-1:0] e;
        hit  = 1'b0;
        data = '0;
`ifdef WB_STAGE_BUF_FWD_EN
        if (a != 0) begin
            for (int i = exp_q.size() - 1; i >= 0 && !hit; i--) begin
                e = exp_q[i];
                for (int l = LANES - 1; l >= 0 && !hit; l--) begin
                    if (e[RD_W + VD_W + l] && e[l*ADDR_W +: ADDR_W] == a) begin
                        hit  = 1'b1;
                        data = e[RD_W + l*DATA_W +: DATA_W];
                    end
                end
            end
        end
`endif
    endtask

    // Check one cycle's outputs against the model, advance the model, cross the clock edge.
    task automatic step();
        logic             e_ir;
        logic             e_ov;
        logic [ENT_W-1:0] head;
        logic             e_hit;
        logic [DATA_W-1:0] e_data;
        #2;
        e_ir = (exp_q.size() != DEPTH) && !hold && rdy;
        e_ov = (exp_q.size() != 0) && !hold && rdy;
        head = (exp_q.size() != 0) ? exp_q[0] : '0;
        model_fwd(fwd_addr, e_hit, e_data);
        check("in_ready",  64'(in_ready),  64'(e_ir));
        check("out_valid", 64'(out_valid), 64'(e_ov));
        check("out_rd",    64'(out_rd),    64'(head[RD_W-1:0]));
        check("out_vd",    64'(out_vd),    64'(head[RD_W +: VD_W]));
        check("out_we",    64'(out_we),    64'(head[RD_W + VD_W +: LANES]));
        check("fwd_hit",   64'(fwd_hit),   64'(e_hit));
        check("fwd_data",  64'(fwd_data),  64'(e_data));
        if (rst) begin
            exp_q.delete();
        end else if (rdy) begin
            if (flush) begin
                exp_q.delete();
            end else begin
                if (e_ov && out_ready) void'(exp_q.pop_front());
                if (in_valid && e_ir) exp_q.push_back(make_entry(in_rd, in_vd, in_we));
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Driver tasks
    task automatic set_idle();
        rst = 1'b0; rdy = 1'b1; hold = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_rd = '0; in_vd = '0; in_we = '0;
        out_ready = 1'b0; fwd_addr = '0;
    endtask

    task automatic set_push(input logic [ADDR_W-1:0] rd0, input logic [DATA_W-1:0] vd0, input logic we0,
                            input logic [ADDR_W-1:0] rd1, input logic [DATA_W-1:0] vd1, input logic we1);
        in_valid = 1'b1;
        in_rd    = {rd1, rd0};
        in_vd    = {vd1, vd0};
        in_we    = {we1, we0};
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        do_reset();
        step();

        // Single push, then inspect the head with the buffer not draining.
        set_push(5'd5, 32'hDEADBEEF, 1'b1, 5'd0, 32'h0, 1'b0);
        step();
        set_idle();
        #2;
        check("tp_single_valid", 64'(out_valid), 64'd1);
        check("tp_single_rd", 64'(out_rd[ADDR_W-1:0]), 64'd5);
        check("tp_single_vd", 64'(out_vd[DATA_W-1:0]), 64'hDEADBEEF);
        check("tp_single_we", 64'(out_we[0]), 64'd1);
        step();

        // Fill to capacity: third entry refused, then drain in order.
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            set_push(5'(i), 32'(i * 16'h1111), 1'b1, 5'(i + 8), 32'(i), 1'b1);
            step();
        end
        set_idle();
        #2;
        check("tp_full_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // Streaming: one entry per cycle across pointer wrap.
        for (int i = 0; i < 8; i++) begin
            set_push(5'($urandom_range(1, 31)), $urandom, 1'b1, 5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)));
            out_ready = 1'b1;
            step();
        end
        set_idle();
        out_ready = 1'b1;
        step();
        step();

        // x0 suppression, then flush racing a push.
        set_push(5'd0, 32'h1234, 1'b1, 5'd0, 32'h5678, 1'b1);
        step();
        set_idle();
        #2;
        check("tp_x0_we", 64'(out_we), 64'd0);
        set_push(5'd3, 32'h33, 1'b1, 5'd0, 32'h0, 1'b0);
        flush = 1'b1;
        step();
        set_idle();
        #2;
        check("tp_flush_valid", 64'(out_valid), 64'd0);
        step();

        // Hold with two entries queued.
        set_push(5'd10, 32'hA, 1'b1, 5'd11, 32'hB, 1'b1);
        step();
        set_push(5'd12, 32'hC, 1'b1, 5'd13, 32'hD, 1'b0);
        step();
        set_idle();
        out_ready = 1'b1;
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            hold = 1'b1;
        end
        hold = 1'b0;
        #2;
        check("tp_hold_head_rd", 64'(out_rd[ADDR_W-1:0]), 64'd10);
        step();
        step();

        // Forwarding priority: newest entry, then highest lane.
        do_reset();
        set_push(5'd7, 32'd1, 1'b1, 5'd7, 32'd2, 1'b1);
        step();
        set_idle();
        fwd_addr = 5'd7;
        #2;
`ifdef WB_STAGE_BUF_FWD_EN
        check("tp_fwd_a_data", 64'(fwd_data), 64'd2);
`else
        check("tp_fwd_off_hit", 64'(fwd_hit), 64'd0);
`endif
        step();
        set_push(5'd7, 32'd3, 1'b1, 5'd0, 32'd0, 1'b0);
        fwd_addr = 5'd7;
        step();
        set_idle();
        fwd_addr = 5'd7;
        #2;
`ifdef WB_STAGE_BUF_FWD_EN
        check("tp_fwd_b_hit", 64'(fwd_hit), 64'd1);
        check("tp_fwd_b_data", 64'(fwd_data), 64'd3);
`else
        check("tp_fwd_off_hit", 64'(fwd_hit), 64'd0);
`endif
        out_ready = 1'b1;
        step();
        set_idle();
        fwd_addr = 5'd7;
        step();

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            rdy       = ($urandom_range(0, 9) != 0);
            hold      = ($urandom_range(0, 7) == 0);
            flush     = ($urandom_range(0, 24) == 0);
            in_valid  = 1'($urandom_range(0, 1));
            in_rd     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            in_vd     = {$urandom, $urandom};
            in_we     = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 2) != 0);
            fwd_addr  = 5'($urandom_range(0, 7));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
